// File: rtl/pc_next_unit_pkg.sv
// pc_next_unit_pkg: pc_sel encodings, FSM state type and default vectors shared by the PC stage
package pc_next_unit_pkg;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
endpackage

// File: rtl/pc_next_unit_target_gen.sv
// pc_target_gen: from pc/pc_sel/imm/rs1 produce seq (pc+INC), selected target and its misaligned flag
module pc_target_gen
  import pc_next_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int INC              = 4,
  parameter int ALLOW_COMPRESSED = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] seq,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  localparam logic [XLEN-1:0] INC_W    = XLEN'(INC);
  localparam logic [XLEN-1:0] LSB_MASK = ~XLEN'(1);
  logic [XLEN-1:0] br;
  logic [XLEN-1:0] jalr;
  always_comb begin
    seq        = pc + INC_W;
    br         = pc + imm;
    jalr       = (rs1 + imm) & LSB_MASK;
    target     = pc_sel == PC_BR ? br : pc_sel == PC_JALR ? jalr : seq;
    misaligned = ALLOW_COMPRESSED != 0 ? target[0] : |target[1:0];
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered PC with BOOT/RUN/TRAP FSM; in clk,reset,stall,pc_sel,imm,rs1; out pc_out,pc_plus_inc,instr_valid,trap_taken,epc_out
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR     = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR      = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              INC              = 4,
  parameter int              ALLOW_COMPRESSED = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            instr_valid,
  output logic            trap_taken,
  output logic [XLEN-1:0] epc_out
);
  state_t          state, state_next;
  logic [XLEN-1:0] pc_next, epc_next, target;
  logic            misaligned, go;
  pc_target_gen #(
    .XLEN(XLEN),
    .INC(INC),
    .ALLOW_COMPRESSED(ALLOW_COMPRESSED)
  ) u_gen (
    .pc(pc_out),
    .pc_sel(pc_sel),
    .imm(imm),
    .rs1(rs1),
    .seq(pc_plus_inc),
    .target(target),
    .misaligned(misaligned)
  );
  // BOOT and TRAP are single bubble cycles that always fall through to RUN
  always_comb begin
    go         = state == RUN && !stall;
    state_next = go && misaligned ? TRAP : RUN;
    pc_next    = !go ? pc_out : misaligned ? TRAP_VECTOR : target;
    epc_next   = go && misaligned ? pc_out : epc_out;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BOOT;
      pc_out  <= RESET_VECTOR;
      epc_out <= '0;
    end else begin
      state   <= state_next;
      pc_out  <= pc_next;
      epc_out <= epc_next;
    end
  end
  assign instr_valid = state == RUN;
  assign trap_taken  = state == TRAP;
endmodule
